// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: master FSM states and response codes.
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WAIT_B = 3'd2,
        RD     = 3'd3,
        WAIT_R = 3'd4,
        RSP    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_master_cmd.sv
// AXI4-Lite initiator: one single-word command in, one AXI-Lite read or write
// out, one response back. Only one transaction is ever in flight.
// Optional watchdog: define AXIL_MASTER_TIMEOUT_EN to enable the sticky
// timeout flag; without it the timeout output is tied low.
module axil_master_cmd
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // Command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    // Response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    // AW channel
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    // W channel
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    // B channel
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AR channel
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    // R channel
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    // Watchdog
    output logic                  timeout
);

    // A zero limit would flag on the very first busy cycle.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
        $error("axil_master_cmd: TIMEOUT_CYCLES must be >= 1");
    end

    state_t                state_q, state_d;
    logic                  aw_done_q, w_done_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           rsp_rdata_q;
    logic [1:0]            rsp_resp_q;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

    // Every handshake strobe and every bus output decodes from registered
    // state, so there is no combinational path from cmd_* to the AXI side.
    assign cmd_ready = (state_q == IDLE);
    assign awvalid   = (state_q == WR) && !aw_done_q;
    assign wvalid    = (state_q == WR) && !w_done_q;
    assign bready    = (state_q == WAIT_B);
    assign arvalid   = (state_q == RD);
    assign rready    = (state_q == WAIT_R);
    assign rsp_valid = (state_q == RSP);

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid && bready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign rsp_hs = rsp_valid && rsp_ready;

    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign awprot    = 3'b000;
    assign arprot    = 3'b000;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: sequential state is updated with <= so every flop samples
        // the pre-edge values regardless of block evaluation order.
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode; AW and W may complete in either order or together.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_hs) state_d = cmd_write ? WR : RD;
            WR:      if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WAIT_B;
            WAIT_B:  if (b_hs) state_d = RSP;
            RD:      if (ar_hs) state_d = WAIT_R;
            WAIT_R:  if (r_hs) state_d = RSP;
            RSP:     if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command capture, per-channel completion flags and response capture.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: payload and response registers are reset too, so the bus
        // and response ports read as zero after reset rather than X.
        if (!aresetn) begin
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            if (cmd_hs) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (b_hs) begin
                rsp_rdata_q <= '0;
                rsp_resp_q  <= bresp;
            end
            if (r_hs) begin
                rsp_rdata_q <= rdata;
                rsp_resp_q  <= rresp;
            end
        end
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic [31:0] wd_cnt_q;
    logic        timeout_q;
    logic        busy;

    assign busy    = (state_q == WR) || (state_q == WAIT_B) ||
                     (state_q == RD) || (state_q == WAIT_R);
    assign timeout = timeout_q;

    // Watchdog: counts busy cycles from command accept; the flag only
    // reports, the transaction keeps waiting so the bus stays legal.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (cmd_hs) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (busy) begin
            if (wd_cnt_q != 32'hFFFF_FFFF) wd_cnt_q <= wd_cnt_q + 32'd1;
            if (wd_cnt_q + 32'd1 >= 32'(TIMEOUT_CYCLES)) timeout_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axil_master_cmd.sv
// Directed bench for axil_master_cmd against a small register-file slave
// with programmable AW/W ready delays. Registers at 0x0/0x4/0x8 answer OKAY;
// 0xC is undecoded and answers SLVERR.
module tb_axil_master_cmd;

    localparam int ADDR_W = 4;
`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam logic EXP_TIMEOUT = 1'b1;
`else
    localparam logic EXP_TIMEOUT = 1'b0;
`endif

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [31:0]       cmd_wdata = '0;
    logic [3:0]        cmd_wstrb = '0;
    logic              rsp_valid, rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic              awvalid, awready = 1'b0;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid, wready = 1'b0;
    logic [1:0]        bresp = 2'b00;
    logic              bvalid = 1'b0, bready;
    logic              arvalid, arready = 1'b0;
    logic [31:0]       rdata = '0;
    logic [1:0]        rresp = 2'b00;
    logic              rvalid = 1'b0, rready;
    logic              timeout;

    axil_master_cmd #(.ADDR_WIDTH(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .timeout(timeout)
    );

    always #5 aclk = ~aclk;

    // ---------------- slave model ----------------
    int          aw_lat = 0, w_lat = 0;
    int          aw_cnt = 0, w_cnt = 0;
    int          aw_beats = 0, w_beats = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] sregs [0:3];

    // Handshakes seen at the rising edge, with their payloads.
    logic              aw_hs_p = 1'b0, w_hs_p = 1'b0, b_hs_p = 1'b0;
    logic              ar_hs_p = 1'b0, r_hs_p = 1'b0;
    logic [ADDR_W-1:0] aw_addr_p = '0, ar_addr_p = '0;
    logic [31:0]       w_data_p = '0;
    logic [3:0]        w_strb_p = '0;

    always @(posedge aclk) begin
        aw_hs_p = aresetn && awvalid && awready;
        w_hs_p  = aresetn && wvalid && wready;
        b_hs_p  = aresetn && bvalid && bready;
        ar_hs_p = aresetn && arvalid && arready;
        r_hs_p  = aresetn && rvalid && rready;
        if (aw_hs_p) aw_addr_p = awaddr;
        if (w_hs_p) begin
            w_data_p = wdata;
            w_strb_p = wstrb;
        end
        if (ar_hs_p) ar_addr_p = araddr;
    end

    // Slave outputs change on the falling edge only.
    always @(negedge aclk) begin
        if (!aresetn) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
            rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00; rdata = '0;
            aw_cnt = 0; w_cnt = 0; aw_got = 1'b0; w_got = 1'b0;
        end else begin
            if (b_hs_p) bvalid = 1'b0;
            if (r_hs_p) begin
                rvalid = 1'b0;
                rdata  = '0;
            end
            if (aw_hs_p) begin
                awready = 1'b0; aw_cnt = 0; aw_got = 1'b1; aw_beats++;
            end else if (awvalid && !awready) begin
                if (aw_cnt >= aw_lat) awready = 1'b1;
                else aw_cnt++;
            end
            if (w_hs_p) begin
                wready = 1'b0; w_cnt = 0; w_got = 1'b1; w_beats++;
            end else if (wvalid && !wready) begin
                if (w_cnt >= w_lat) wready = 1'b1;
                else w_cnt++;
            end
            if (aw_got && w_got && !bvalid) begin
                if (aw_addr_p[3:2] == 2'd3) begin
                    bresp = 2'b10;
                end else begin
                    bresp = 2'b00;
                    for (int b = 0; b < 4; b++)
                        if (w_strb_p[b]) sregs[aw_addr_p[3:2]][8*b +: 8] = w_data_p[8*b +: 8];
                end
                bvalid = 1'b1; aw_got = 1'b0; w_got = 1'b0;
            end
            if (ar_hs_p) begin
                arready = 1'b0;
                if (ar_addr_p[3:2] == 2'd3) begin
                    rresp = 2'b10; rdata = '0;
                end else begin
                    rresp = 2'b00; rdata = sregs[ar_addr_p[3:2]];
                end
                rvalid = 1'b1;
            end else if (arvalid && !arready) begin
                arready = 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One command end to end: accept, latency, response, hold, handshake.
    task automatic do_cmd(input string tag, input logic wr, input logic [3:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws, input int hold,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                          input int exp_lat);
        int n;
        int lat;
        int aw0, w0;
        aw0 = aw_beats;
        w0  = w_beats;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "/cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        @(negedge aclk);
        cmd_valid = 1'b0;
        check({tag, "/cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge aclk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/rsp_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "/rsp_resp"}, 32'(rsp_resp), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "/hold_rdata"}, rsp_rdata, exp_rdata);
            check({tag, "/hold_resp"}, 32'(rsp_resp), 32'(exp_resp));
            check({tag, "/hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check({tag, "/rsp_valid_after"}, 32'(rsp_valid), 32'd0);
        check({tag, "/cmd_ready_after"}, 32'(cmd_ready), 32'd1);
        if (wr) begin
            check({tag, "/aw_beats"}, 32'(aw_beats - aw0), 32'd1);
            check({tag, "/w_beats"}, 32'(w_beats - w0), 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) sregs[i] = '0;
        repeat (2) @(negedge aclk);

        // Reset state
        check("rst/cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst/awvalid", 32'(awvalid), 32'd0);
        check("rst/wvalid", 32'(wvalid), 32'd0);
        check("rst/arvalid", 32'(arvalid), 32'd0);
        check("rst/bready", 32'(bready), 32'd0);
        check("rst/rready", 32'(rready), 32'd0);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_rdata", rsp_rdata, 32'd0);
        check("rst/rsp_resp", 32'(rsp_resp), 32'd0);
        check("rst/awaddr", 32'(awaddr), 32'd0);
        check("rst/wdata", wdata, 32'd0);
        check("rst/timeout", 32'(timeout), 32'd0);
        aresetn = 1'b1;

        // Zero-wait write then read-back with a 5-cycle response stall
        do_cmd("wr4", 1'b1, 4'h4, 32'h0000_1234, 4'hF, 0, 32'h0, 2'b00, 3);
        check("wr4/reg1", sregs[1], 32'h0000_1234);
        do_cmd("rd4", 1'b0, 4'h4, 32'h0, 4'h0, 5, 32'h0000_1234, 2'b00, 3);

        // W ready late, then AW ready late; partial strobes on the first
        w_lat = 3;
        do_cmd("wr8_wlate", 1'b1, 4'h8, 32'hA5A5_0F0F, 4'b0101, 0, 32'h0, 2'b00, 6);
        check("wr8_wlate/reg2", sregs[2], 32'h00A5_000F);
        w_lat = 0; aw_lat = 3;
        do_cmd("wr0_awlate", 1'b1, 4'h0, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, 2'b00, 6);
        check("wr0_awlate/reg0", sregs[0], 32'hDEAD_BEEF);
        aw_lat = 0;
        do_cmd("rd8", 1'b0, 4'h8, 32'h0, 4'h0, 0, 32'h00A5_000F, 2'b00, 3);

        // Slave error passes through on both directions
        do_cmd("rdC", 1'b0, 4'hC, 32'h0, 4'h0, 0, 32'h0, 2'b10, 3);
        do_cmd("wrC", 1'b1, 4'hC, 32'h0000_FFFF, 4'hF, 0, 32'h0, 2'b10, 3);

        // Stalled AW: watchdog, then asynchronous reset mid-transaction
        aw_lat = 100000;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4;
        cmd_wdata = 32'h0BAD_0BAD; cmd_wstrb = 4'hF;
        @(negedge aclk);
        cmd_valid = 1'b0;
        check("stall/awvalid_t0", 32'(awvalid), 32'd1);
        check("stall/awprot", 32'(awprot), 32'd0);
        repeat (15) @(negedge aclk);
        check("stall/timeout_t15", 32'(timeout), 32'd0);
        @(negedge aclk);
        check("stall/timeout_t16", 32'(timeout), 32'(EXP_TIMEOUT));
        check("stall/awvalid_t16", 32'(awvalid), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("arst/awvalid", 32'(awvalid), 32'd0);
        check("arst/wvalid", 32'(wvalid), 32'd0);
        check("arst/arvalid", 32'(arvalid), 32'd0);
        check("arst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst/cmd_ready", 32'(cmd_ready), 32'd1);
        check("arst/timeout", 32'(timeout), 32'd0);
        @(negedge aclk);
        aw_lat = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        check("arst/reg1_kept", sregs[1], 32'h0000_1234);

        // Recovery after reset
        do_cmd("rd4_post_rst", 1'b0, 4'h4, 32'h0, 4'h0, 0, 32'h0000_1234, 2'b00, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit reached");
    end

endmodule
